inv_mix_columns_seq: RTL and testbench

Column-serial AES InvMixColumns engine for the decrypt datapath of the execute stage. It accepts a 128-bit state through a valid/ready handshake and multiplies each 32-bit column by the inverse MixColumns matrix {0E,0B,0D,09} (circulant) over GF(2^8), processing COLS_PER_CYCLE columns per clock. The registered result is held on the output until the consumer accepts it. Area is traded against latency, unlike the fully combinational forward MixColumns path.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/inv_mix_columns_seq_if.sv | 22 ++
 rtl/inv_mix_columns_seq_column.sv | 22 ++
 rtl/inv_mix_columns_seq.sv | 85 ++++++++
 tb/tb_inv_mix_columns_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, InvMixColumns coefficients and GF(2^8) helpers.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  column_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsm_t;

  localparam logic [7:0] INV_MIX_0E = 8'h0E;
  localparam logic [7:0] INV_MIX_0B = 8'h0B;
  localparam logic [7:0] INV_MIX_0D = 8'h0D;
  localparam logic [7:0] INV_MIX_09 = 8'h09;
  localparam logic [7:0] AES_POLY   = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Column 0 occupies the most significant word of the state.
  function automatic column_t col_get(input state_t s, input logic [1:0] idx);
    case (idx)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  function automatic state_t col_put(input state_t s, input logic [1:0] idx, input column_t c);
    state_t r;
    r = s;
    case (idx)
      2'd0:    r[127:96] = c;
      2'd1:    r[95:64]  = c;
      2'd2:    r[63:32]  = c;
      default: r[31:0]   = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Input/output handshake bundle for the column-serial InvMixColumns engine.
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic   inValid;
  logic   inReady;
  state_t stateIn;
  logic   outValid;
  logic   outReady;
  state_t stateOut;
  logic   busy;

  modport master (
    output inValid, stateIn, outReady,
    input  inReady, outValid, stateOut, busy
  );

  modport slave (
    input  inValid, stateIn, outReady,
    output inReady, outValid, stateOut, busy
  );
endinterface

// File: rtl/inv_mix_columns_seq_column.sv
// Combinational InvMixColumns transform of one 32-bit column (row-0 byte in MSB).
module inv_mix_column
  import aes_pkg::*;
(
  input  column_t col_in,
  output column_t col_out
);

  logic [7:0] s0, s1, s2, s3;

  assign {s0, s1, s2, s3} = col_in;

  assign col_out[31:24] = gf_mul8(s0, INV_MIX_0E) ^ gf_mul8(s1, INV_MIX_0B)
                        ^ gf_mul8(s2, INV_MIX_0D) ^ gf_mul8(s3, INV_MIX_09);
  assign col_out[23:16] = gf_mul8(s0, INV_MIX_09) ^ gf_mul8(s1, INV_MIX_0E)
                        ^ gf_mul8(s2, INV_MIX_0B) ^ gf_mul8(s3, INV_MIX_0D);
  assign col_out[15:8]  = gf_mul8(s0, INV_MIX_0D) ^ gf_mul8(s1, INV_MIX_09)
                        ^ gf_mul8(s2, INV_MIX_0E) ^ gf_mul8(s3, INV_MIX_0B);
  assign col_out[7:0]   = gf_mul8(s0, INV_MIX_0B) ^ gf_mul8(s1, INV_MIX_0D)
                        ^ gf_mul8(s2, INV_MIX_09) ^ gf_mul8(s3, INV_MIX_0E);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: captures a state, transforms COLS_PER_CYCLE
// columns per clock, and holds the registered result until accepted.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  inv_mix_columns_seq_if.slave bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Both wrap in 2 bits: with 4 columns per cycle the step and last slice are 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  fsm_t       state_q, state_d;
  logic [1:0] col_q, col_d;
  state_t     work_q, work_d;
  state_t     out_q, out_d;
  logic       accept;

  logic [1:0] sel     [COLS_PER_CYCLE];
  column_t    col_res [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign sel[k] = col_q + 2'(k);
    inv_mix_column u_col (
      .col_in  (col_get(work_q, sel[k])),
      .col_out (col_res[k])
    );
  end

  assign bus.inReady  = rst_n && (state_q == IDLE);
  assign bus.outValid = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.stateOut = out_q;
  assign accept       = bus.inValid && bus.inReady;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = bus.stateIn;
          col_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
          out_d = col_put(out_d, sel[k], col_res[k]);
        end
        col_d = col_q + COL_STEP;
        if (col_q == LAST_COL) state_d = DONE;
      end
      DONE: begin
        if (bus.outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq at 1, 2 and 4 columns per cycle against a
// polynomial-arithmetic matrix model.
module tb_inv_mix_columns_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_mix_columns_seq_if bus1 ();
  inv_mix_columns_seq_if bus2 ();
  inv_mix_columns_seq_if bus4 ();

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic   in_valid  [3];
  logic   out_ready [3];
  state_t state_in  [3];
  logic   in_ready  [3];
  logic   out_valid [3];
  logic   busy      [3];
  state_t state_out [3];

  assign bus1.inValid = in_valid[0];  assign bus1.outReady = out_ready[0];  assign bus1.stateIn = state_in[0];
  assign bus2.inValid = in_valid[1];  assign bus2.outReady = out_ready[1];  assign bus2.stateIn = state_in[1];
  assign bus4.inValid = in_valid[2];  assign bus4.outReady = out_ready[2];  assign bus4.stateIn = state_in[2];
  assign in_ready[0] = bus1.inReady;  assign out_valid[0] = bus1.outValid;
  assign in_ready[1] = bus2.inReady;  assign out_valid[1] = bus2.outValid;
  assign in_ready[2] = bus4.inReady;  assign out_valid[2] = bus4.outValid;
  assign busy[0] = bus1.busy;  assign state_out[0] = bus1.stateOut;
  assign busy[1] = bus2.busy;  assign state_out[1] = bus2.stateOut;
  assign busy[2] = bus4.busy;  assign state_out[2] = bus4.stateOut;

  int checks = 0;
  int failures = 0;

  localparam state_t FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam state_t FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam state_t RST_IN   = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;
  localparam state_t RST_OUT  = 128'h2d26314c_2d26314c_2d26314c_2d26314c;

  // Carry-less product then reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix whose first row is {m0,m1,m2,m3}, applied to every column.
  function automatic state_t mix(input state_t s, input logic [7:0] m0, input logic [7:0] m1,
                                 input logic [7:0] m2, input logic [7:0] m3);
    logic [7:0] m [4];
    logic [7:0] b [16];
    logic [7:0] acc;
    state_t r;
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - row + 4) % 4], b[4*c + j]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int d, output int n);
    n = 0;
    while (!out_valid[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with it idle again.
  task automatic run_fixed(input int d, input state_t vec, input state_t exp, input int lat,
                           input string tag);
    int n;
    in_valid[d] = 1'b1; state_in[d] = vec; out_ready[d] = 1'b0;
    check({tag, "_in_ready"}, in_ready[d], 1'b1);
    @(negedge clk);
    in_valid[d] = 1'b0; state_in[d] = rand_state();
    check({tag, "_busy"}, busy[d], 1'b1);
    check({tag, "_in_ready_calc"}, in_ready[d], 1'b0);
    wait_valid(d, n);
    check({tag, "_latency"}, n, lat);
    check({tag, "_result"}, state_out[d], exp);
    out_ready[d] = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid[d], 1'b0);
    check({tag, "_in_ready_back"}, in_ready[d], 1'b1);
    out_ready[d] = 1'b0;
  endtask

  task automatic rand_run(input int d, input int nblk);
    state_t q[$];
    state_t src;
    int acc = 0;
    int got = 0;
    int cyc = 0;
    while (got < nblk && cyc < nblk * 40) begin
      @(negedge clk);
      cyc++;
      in_valid[d]  = (acc < nblk) && ($urandom_range(1, 0) == 1);
      state_in[d]  = rand_state();
      out_ready[d] = ($urandom_range(1, 0) == 1);
      if (in_valid[d] && in_ready[d]) begin
        q.push_back(state_in[d]);
        acc++;
      end
      if (out_valid[d] && out_ready[d]) begin
        if (q.size() == 0) begin
          check("rand_spurious_valid", 1'b1, 1'b0);
        end else begin
          src = q.pop_front();
          check("rand_inverse", state_out[d], mix(src, 8'h0E, 8'h0B, 8'h0D, 8'h09));
          check("rand_forward", mix(state_out[d], 8'h02, 8'h03, 8'h01, 8'h01), src);
        end
        got++;
      end
    end
    in_valid[d] = 1'b0;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check("rand_drained", got, nblk);
  endtask

  initial begin
    int n;
    state_t blk_b;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; state_in[d] = '0;
    end

    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", in_ready[d], 1'b0);
      check("rst_out_valid", out_valid[d], 1'b0);
      check("rst_busy", busy[d], 1'b0);
      check("rst_state_out", state_out[d], 128'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check("rel_in_ready", in_ready[d], 1'b1);

    // Known vectors at each column width
    run_fixed(0, FIPS_IN, FIPS_OUT, 4, "fips_c1");
    run_fixed(1, FIPS_IN, FIPS_OUT, 2, "fips_c2");
    run_fixed(2, FIPS_IN, FIPS_OUT, 1, "fips_c4");

    // Backpressure with a competing input held valid
    in_valid[0] = 1'b1; state_in[0] = FIPS_IN;
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_valid(0, n);
    check("bp_latency", n, 4);
    blk_b = rand_state();
    in_valid[0] = 1'b1; state_in[0] = blk_b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_out", state_out[0], FIPS_OUT);
      check("bp_hold_valid", out_valid[0], 1'b1);
      check("bp_in_ready", in_ready[0], 1'b0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_release_valid", out_valid[0], 1'b0);
    check("bp_release_ready", in_ready[0], 1'b1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_second_busy", busy[0], 1'b1);
    wait_valid(0, n);
    check("bp_second_latency", n, 4);
    check("bp_second_result", state_out[0], mix(blk_b, 8'h0E, 8'h0B, 8'h0D, 8'h09));
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_second_done", out_valid[0], 1'b0);

    // Reset during the second CALC cycle
    in_valid[0] = 1'b1; state_in[0] = RST_IN;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid[0], 1'b0);
    check("abort_state_out", state_out[0], 128'h0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_in_ready", in_ready[0], 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid[0], 1'b0);
    end
    run_fixed(0, RST_IN, RST_OUT, 4, "after_abort");

    // Random traffic with random handshakes
    rand_run(0, 1000);
    rand_run(1, 300);
    rand_run(2, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
